// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-ported data memory
// with a registered read port; partial-word stores become read-modify-write.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [BE_WIDTH-1:0]   r0_be,
  input  logic [DATA_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rsp,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [BE_WIDTH-1:0]   r1_be,
  input  logic [DATA_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rsp,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int LANE_BITS = (BE_WIDTH > 1) ? $clog2(BE_WIDTH) : 0;
  localparam logic [DATA_WIDTH-1:0] ADDR_MASK = {DATA_WIDTH{1'b1}} << LANE_BITS;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA,
    RMW_RD,
    RMW_WR
  } state_t;

  state_t                state_reg, state_next;
  // last_reg is both the round-robin pointer and the owner of the transaction in flight
  logic                  last_reg;
  logic [BE_WIDTH-1:0]   be_reg;
  logic [DATA_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  logic [1:0]            req_valid;
  logic [1:0]            req_we;
  logic [BE_WIDTH-1:0]   req_be    [2];
  logic [DATA_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];

  logic                  grant_valid;
  logic                  grant_id;
  logic [1:0]            ready_vec;
  logic                  rsp_pulse;
  logic [1:0]            rsp_vec;
  logic [DATA_WIDTH-1:0] rdata_vec [2];
  logic [DATA_WIDTH-1:0] merged_wd;

  assign req_valid    = {r1_valid, r0_valid};
  assign req_we       = {r1_we, r0_we};
  assign req_be[0]    = r0_be;
  assign req_be[1]    = r1_be;
  assign req_addr[0]  = r0_addr;
  assign req_addr[1]  = r1_addr;
  assign req_wdata[0] = r0_wdata;
  assign req_wdata[1] = r1_wdata;

  // Arbitration only happens in IDLE; on a tie the requester not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (!rst && state_reg == IDLE) begin
      if (req_valid == 2'b11) begin
        grant_valid = 1'b1;
        grant_id    = ~last_reg;
      end else if (req_valid[0]) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (req_valid[1]) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign ready_vec = grant_valid ? (2'b01 << grant_id) : 2'b00;
  assign r0_ready  = ready_vec[0];
  assign r1_ready  = ready_vec[1];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          if (!req_we[grant_id]) begin
            state_next = RD_ADDR;
          end else if (req_be[grant_id] == '1 || req_be[grant_id] == '0) begin
            state_next = WRITE;
          end else begin
            state_next = RMW_RD;
          end
        end
      end
      WRITE:   state_next = IDLE;
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = IDLE;
      RMW_RD:  state_next = RMW_WR;
      RMW_WR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      be_reg    <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_valid) begin
        last_reg  <= grant_id;
        be_reg    <= req_be[grant_id];
        addr_reg  <= req_addr[grant_id] & ADDR_MASK;
        wdata_reg <= req_wdata[grant_id];
      end
    end
  end

  // Lanes not enabled keep the word returned by the RMW_RD read.
  for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_merge
    assign merged_wd[gi*8 +: 8] = be_reg[gi] ? wdata_reg[gi*8 +: 8] : mem_rd[gi*8 +: 8];
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    rsp_pulse = 1'b0;
    case (state_reg)
      WRITE: begin
        mem_we    = (be_reg != '0);
        mem_a     = addr_reg;
        mem_wd    = wdata_reg;
        rsp_pulse = 1'b1;
      end
      RD_ADDR, RMW_RD: begin
        mem_a  = addr_reg;
        mem_wd = wdata_reg;
      end
      RD_DATA: begin
        mem_a     = addr_reg;
        mem_wd    = wdata_reg;
        rsp_pulse = 1'b1;
      end
      RMW_WR: begin
        mem_we    = 1'b1;
        mem_a     = addr_reg;
        mem_wd    = merged_wd;
        rsp_pulse = 1'b1;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
    // A transaction caught by reset is dropped without touching memory.
    if (rst) begin
      mem_we    = 1'b0;
      mem_a     = '0;
      mem_wd    = '0;
      rsp_pulse = 1'b0;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rsp_vec[gi]   = rsp_pulse && (last_reg == 1'(gi));
    assign rdata_vec[gi] = (rsp_vec[gi] && state_reg == RD_DATA) ? mem_rd : '0;
  end

  assign r0_rsp   = rsp_vec[0];
  assign r1_rsp   = rsp_vec[1];
  assign r0_rdata = rdata_vec[0];
  assign r1_rdata = rdata_vec[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, transaction-timeline scoreboard checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_valid, r0_ready, r0_we, r0_rsp;
  logic [3:0]  r0_be;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_rsp;
  logic [3:0]  r1_be;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int n_vec = 0;
  int n_bad = 0;

  dmem_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_be(r0_be),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_rsp(r0_rsp), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_be(r1_be),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rsp(r1_rsp), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0F0F ^ (32'(i) * 32'h0101_0103);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: 16 words aliased on address bits [5:2], registered read-first port.
  logic [31:0] mem_array [16];
  initial begin
    for (int i = 0; i < 16; i++) mem_array[i] <= init_word(i);
    mem_array[8] <= 32'h1122_3344;
    mem_rd <= '0;
    forever begin
      @(posedge clk);
      if (mem_we) mem_array[mem_a[5:2]] <= mem_wd;
      mem_rd <= mem_array[mem_a[5:2]];
    end
  end

  // Reference: each accepted transaction books its expected outputs into the
  // cycles after acceptance; unbooked cycles expect all-zero memory/rsp outputs.
  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [1:0]  rsp;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        commit;
    logic [3:0]  cidx;
    logic [31:0] cval;
  } slot_t;

  slot_t       slots [4];
  logic [31:0] ref_mem [16];
  int          cyc;
  int          free_at;
  logic        last_m;
  logic [1:0]  dut_hs;

  initial begin
    slot_t       s;
    logic [1:0]  v, er;
    logic        gid, pwe;
    logic [3:0]  pb, idx;
    logic [31:0] pa, pw, maddr, merged;
    int          t1, t2;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    ref_mem[8] = 32'h1122_3344;
    for (int k = 0; k < 4; k++) slots[k] = '0;
    cyc = 0; free_at = 0; last_m = 1'b1; dut_hs = 2'b00;
    forever begin
      @(negedge clk);
      s = slots[cyc % 4];
      slots[cyc % 4] = '0;
      if (rst) begin
        check("rst_ready0", {31'd0, r0_ready}, 32'd0);
        check("rst_ready1", {31'd0, r1_ready}, 32'd0);
        check("rst_rsp0", {31'd0, r0_rsp}, 32'd0);
        check("rst_rsp1", {31'd0, r1_rsp}, 32'd0);
        check("rst_rdata0", r0_rdata, 32'd0);
        check("rst_rdata1", r1_rdata, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        for (int k = 0; k < 4; k++) slots[k] = '0;
        last_m = 1'b1;
        free_at = cyc + 1;
        dut_hs = 2'b00;
      end else begin
        v = {r1_valid, r0_valid};
        er = 2'b00;
        gid = 1'b0;
        if (cyc >= free_at && v != 2'b00) begin
          gid = (v == 2'b11) ? ~last_m : v[1];
          er[gid] = 1'b1;
        end
        check("ready0", {31'd0, r0_ready}, {31'd0, er[0]});
        check("ready1", {31'd0, r1_ready}, {31'd0, er[1]});
        check("mem_we", {31'd0, mem_we}, {31'd0, s.we});
        check("mem_a", mem_a, s.a);
        check("mem_wd", mem_wd, s.wd);
        check("rsp0", {31'd0, r0_rsp}, {31'd0, s.rsp[0]});
        check("rsp1", {31'd0, r1_rsp}, {31'd0, s.rsp[1]});
        check("rdata0", r0_rdata, s.rd0);
        check("rdata1", r1_rdata, s.rd1);
        if (s.commit) ref_mem[s.cidx] = s.cval;
        dut_hs = v & {r1_ready, r0_ready};
        if (er != 2'b00) begin
          last_m = gid;
          pwe = gid ? r1_we    : r0_we;
          pb  = gid ? r1_be    : r0_be;
          pa  = gid ? r1_addr  : r0_addr;
          pw  = gid ? r1_wdata : r0_wdata;
          $display("txn r%0d %s addr=%08h be=%h wdata=%08h", gid, pwe ? "ST" : "LD", pa, pb, pw);
          maddr = {pa[31:2], 2'b00};
          idx = pa[5:2];
          for (int b = 0; b < 4; b++) merged[b*8 +: 8] = pb[b] ? pw[b*8 +: 8] : ref_mem[idx][b*8 +: 8];
          t1 = (cyc + 1) % 4;
          t2 = (cyc + 2) % 4;
          slots[t1].a  = maddr;
          slots[t1].wd = pw;
          if (!pwe) begin
            slots[t2].a = maddr;
            slots[t2].wd = pw;
            slots[t2].rsp[gid] = 1'b1;
            if (gid) slots[t2].rd1 = ref_mem[idx];
            else     slots[t2].rd0 = ref_mem[idx];
            free_at = cyc + 3;
          end else if (pb == 4'hF || pb == 4'h0) begin
            slots[t1].we = (pb != 4'h0);
            slots[t1].rsp[gid] = 1'b1;
            slots[t1].commit = (pb != 4'h0);
            slots[t1].cidx = idx;
            slots[t1].cval = pw;
            free_at = cyc + 2;
          end else begin
            slots[t2].we = 1'b1;
            slots[t2].a = maddr;
            slots[t2].wd = merged;
            slots[t2].rsp[gid] = 1'b1;
            slots[t2].commit = 1'b1;
            slots[t2].cidx = idx;
            slots[t2].cval = merged;
            free_at = cyc + 3;
          end
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (n == 0) begin
      r0_valid = 1'b1; r0_we = we; r0_be = be; r0_addr = addr; r0_wdata = wdata;
    end else begin
      r1_valid = 1'b1; r1_we = we; r1_be = be; r1_addr = addr; r1_wdata = wdata;
    end
  endtask

  task automatic clr_req(input int n);
    if (n == 0) r0_valid = 1'b0;
    else        r1_valid = 1'b0;
  endtask

  task automatic rand_req(input int n);
    logic [3:0] be;
    int sel;
    sel = $urandom_range(0, 3);
    be = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom);
    set_req(n, 1'($urandom_range(0, 1)), be, $urandom, $urandom);
  endtask

  task automatic wait_accept(input int n);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (n == 0) ? r0_ready : r1_ready;
    end
    n_vec++;
    if (!got) begin
      n_bad++;
      $display("FAIL accept_r%0d: ready stayed 0 for 20 cycles, expected 1", n);
    end
  endtask

  initial begin
    int gid_q[$];
    int gcyc_q[$];
    int cnt;
    int exp_ids [4];
    exp_ids = '{0, 1, 0, 1};
    rst = 1'b1;
    r0_valid = 0; r0_we = 0; r0_be = 0; r0_addr = 0; r0_wdata = 0;
    r1_valid = 0; r1_we = 0; r1_be = 0; r1_addr = 0; r1_wdata = 0;
    repeat (3) step();
    rst = 1'b0;

    // Full store then load back
    set_req(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    wait_accept(0);
    step(); clr_req(0);
    @(negedge clk);
    check("full_mem_we", {31'd0, mem_we}, 32'd1);
    check("full_mem_a", mem_a, 32'h10);
    check("full_mem_wd", mem_wd, 32'hDEAD_BEEF);
    check("full_rsp0", {31'd0, r0_rsp}, 32'd1);
    step(); set_req(0, 1'b0, 4'h0, 32'h10, 32'h0);
    wait_accept(0);
    step(); clr_req(0);
    @(negedge clk);
    check("load_rsp0_early", {31'd0, r0_rsp}, 32'd0);
    @(negedge clk);
    check("load_rsp0", {31'd0, r0_rsp}, 32'd1);
    check("load_rdata0", r0_rdata, 32'hDEAD_BEEF);

    // Partial store from r1
    step(); set_req(1, 1'b1, 4'b0010, 32'h20, 32'h0000_AA00);
    wait_accept(1);
    step(); clr_req(1);
    @(negedge clk);
    check("rmw_rd_we", {31'd0, mem_we}, 32'd0);
    check("rmw_rd_rsp1", {31'd0, r1_rsp}, 32'd0);
    @(negedge clk);
    check("rmw_wr_we", {31'd0, mem_we}, 32'd1);
    check("rmw_wr_wd", mem_wd, 32'h1122_AA44);
    check("rmw_rsp1", {31'd0, r1_rsp}, 32'd1);
    check("rmw_rsp0", {31'd0, r0_rsp}, 32'd0);

    // Empty-mask store and unaligned load
    step(); set_req(0, 1'b1, 4'h0, 32'h30, 32'h1234_5678);
    wait_accept(0);
    step(); clr_req(0);
    @(negedge clk);
    check("empty_mem_we", {31'd0, mem_we}, 32'd0);
    check("empty_rsp0", {31'd0, r0_rsp}, 32'd1);
    step(); set_req(0, 1'b0, 4'h0, 32'h13, 32'h0);
    wait_accept(0);
    step(); clr_req(0);
    @(negedge clk);
    check("unaligned_mem_a", mem_a, 32'h10);
    repeat (2) step();

    // Reset during RMW_RD
    set_req(1, 1'b1, 4'b0100, 32'h20, 32'h0055_0000);
    wait_accept(1);
    step(); clr_req(1); rst = 1'b1;
    set_req(0, 1'b0, 4'h0, 32'h08, 32'h0);
    set_req(1, 1'b0, 4'h0, 32'h24, 32'h0);
    @(negedge clk);
    check("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
    check("rstmid_rsp1", {31'd0, r1_rsp}, 32'd0);
    check("rstmid_mem_a", mem_a, 32'd0);
    step();
    @(negedge clk);
    check("rstmid_mem_we2", {31'd0, mem_we}, 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    check("rstmid_tie_r0", {31'd0, r0_ready}, 32'd1);
    check("rstmid_tie_r1", {31'd0, r1_ready}, 32'd0);
    step(); clr_req(0);
    wait_accept(1);
    step(); clr_req(1);
    repeat (3) step();

    // Contention after reset: continuous loads from both sides
    rst = 1'b1;
    step(); step();
    set_req(0, 1'b0, 4'h0, 32'h04, 32'h0);
    set_req(1, 1'b0, 4'h0, 32'h28, 32'h0);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40 && gid_q.size() < 4; k++) begin
      @(negedge clk);
      cnt++;
      if (r0_ready) begin gid_q.push_back(0); gcyc_q.push_back(cnt); end
      if (r1_ready) begin gid_q.push_back(1); gcyc_q.push_back(cnt); end
    end
    n_vec++;
    if (gid_q.size() < 4) begin
      n_bad++;
      $display("FAIL contention_grants: got %0d grants, expected 4", gid_q.size());
    end else begin
      check("cont_first_cycle", gcyc_q[0], 1);
      for (int k = 0; k < 4; k++) check("cont_grant_id", gid_q[k], exp_ids[k]);
      for (int k = 1; k < 4; k++) check("cont_gap", gcyc_q[k] - gcyc_q[k-1], 3);
    end
    step(); clr_req(0); clr_req(1);
    repeat (4) step();

    // Random traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (r0_valid && dut_hs[0]) r0_valid = 1'b0;
      if (r1_valid && dut_hs[1]) r1_valid = 1'b0;
      if (!r0_valid && $urandom_range(0, 2) == 0) rand_req(0);
      if (!r1_valid && $urandom_range(0, 2) == 0) rand_req(1);
    end
    step(); clr_req(0); clr_req(1); rst = 1'b0;
    repeat (6) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. It shares the memory between requester 0 (CPU load/store path) and requester 1 (DMA/debug port) using round-robin arbitration. It also turns byte-masked stores into read-modify-write sequences, because the memory array has only a whole-word write enable and a registered read port. The block sits between the requesters and the data memory instance, and it is the only master of the memory port.

## Interface
- DATA_WIDTH, 32, data and address width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width. Derived; do not override.
- clk  in  1  single clock. All state is updated on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rN_valid  in  1  request valid from requester N (N = 0, 1). Must be held until accepted.
- rN_ready  out  1  grant/accept for requester N. Handshake occurs when rN_valid && rN_ready.
- rN_we  in  1  1 = store, 0 = load.
- rN_be  in  BE_WIDTH  byte enables for stores. Ignored for loads.
- rN_addr  in  DATA_WIDTH  byte address. The low log2(BE_WIDTH) bits are ignored.
- rN_wdata  in  DATA_WIDTH  store data, lane-aligned.
- rN_rsp  out  1  one-cycle completion pulse, issued for both loads and stores.
- rN_rdata  out  DATA_WIDTH  load data. Valid only while rN_rsp is high after a load; 0 otherwise.
- mem_we  out  1  memory write enable.
- mem_a  out  DATA_WIDTH  word-aligned memory address.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  memory read data. Registered: valid the cycle after mem_a is presented with mem_we = 0.

## Operation
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, RMW_RD, RMW_WR.
- IDLE arbitration:
  - If exactly one rN_valid is high, that requester gets rN_ready = 1 (combinational from valid).
  - If both are high, grant the requester not granted last.
  - Priority pointer `last` resets to 1, so requester 0 wins the first tie.
  - At most one ready is high in any cycle. No ready is high outside IDLE.
- On handshake:
  - Latch grant id, we, be, addr with low bits cleared, and wdata.
  - Update `last` to the grant id.
  - Next state:
    - load → RD_ADDR
    - store with be all-ones → WRITE
    - store with be == 0 → WRITE
    - any other store → RMW_RD
- WRITE: mem_we = (be != 0), mem_a = latched addr, mem_wd = wdata. Pulse rsp to the owner. Return to IDLE.
- RD_ADDR: mem_we = 0, mem_a = addr. Go to RD_DATA.
- RD_DATA: owner's rdata = mem_rd, rsp = 1. Return to IDLE.
- RMW_RD: mem_we = 0, mem_a = addr. Go to RMW_WR.
- RMW_WR:
  - mem_we = 1, mem_a = addr.
  - mem_wd byte i = be[i] ? wdata byte i : mem_rd byte i.
  - Pulse rsp. Return to IDLE.
- Outputs in IDLE: mem_we = 0, mem_a = 0, mem_wd = 0. Outside IDLE, mem_a and mem_wd hold the latched values.
- The non-owning requester's rsp and rdata stay 0 throughout.

## Timing
- Handshake in cycle T. Completion:
  - Full or empty store: WRITE at T+1, rsp at T+1, next accept possible at T+2.
  - Load: address at T+1, rsp and rdata at T+2, next accept at T+3.
  - Partial store: read at T+1, merged write and rsp at T+2, next accept at T+3.
- There is no pipelining: one transaction is in flight at a time.
- A requester whose rsp fires in cycle C may reassert valid in C. It is accepted no earlier than C+1, when the FSM is in IDLE.
- A pending rN_valid that loses arbitration waits with payload stable. It wins the next IDLE cycle in which the other requester is also valid.
- Reset values: state IDLE, last = 1, all rN_ready = 0, rN_rsp = 0, rN_rdata = 0, mem_we = 0, mem_a = 0, mem_wd = 0.
- While rst is high, mem_we is forced to 0 and no ready or rsp is driven.
- Reset mid-transaction abandons it silently: no write, no rsp. The requester must reissue.
- Memory contents are not reset.

## Test plan
- Full store, then load:
  - Stimulus: r0 store addr 0x10, wdata 0xDEADBEEF, be 0xF, accepted at T.
  - Required: mem_we = 1, mem_a = 0x10, mem_wd = 0xDEADBEEF at T+1; r0_rsp at T+1.
  - Follow-up: r0 load 0x10 → r0_rsp and r0_rdata = 0xDEADBEEF two cycles after its accept.
- Partial store:
  - Stimulus: mem[0x20] = 0x11223344; r1 store addr 0x20, be 0b0010, wdata 0x0000AA00.
  - Required: mem_we = 0 at T+1; mem_we = 1 and mem_wd = 0x1122AA44 at T+2; r1_rsp at T+2; r0_rsp stays 0.
- Contention: after reset, r0 and r1 both hold loads continuously → grants alternate r0, r1, r0, r1. Each grant is 3 cycles apart and r0 is granted first.
- Empty-mask store and unaligned address:
  - r0 store be = 0 → no mem_we; r0_rsp at T+1.
  - r0 load addr 0x13 → mem_a = 0x10 at T+1.
- Reset mid-operation:
  - Stimulus: assert rst during RMW_RD of a partial store.
  - Required: mem_we never asserted; no rsp; all outputs 0.
  - After rst deasserts with both requesters valid: FSM in IDLE and r0 wins the tie.
